bgpu_instruction_cache: RTL and testbench
=========================================

Name: bgpu_instruction_cache

Overview:
- Direct-mapped, blocking instruction cache between the warp fetcher and the decoder of the BGPU.
- Accepts one fetch request (PC plus warp context) at a time. On a hit it returns the encoded instruction; on a miss it fetches a full cacheline from instruction memory, fills the line and then returns the instruction.
- Responses are strictly in request order.
- A flush input invalidates the whole cache.

Parameters:
- PcWidth, 9: width of the PC; one PC unit addresses one instruction.
- NumWarps, 16: number of warps; warp ID width WidW = max(1, clog2(NumWarps)).
- WarpWidth, 4: threads per warp, which is the active mask width. Subwarp ID width SwW = max(1, clog2(WarpWidth)).
- EncInstWidth, 32: width of an encoded instruction.
- CachelineIdxBits, 2: log2 of instructions per cacheline. LineW = PcWidth - CachelineIdxBits; when this parameter is 0, LineW = PcWidth.
- NumCachelines, 16: number of lines. Must be a power of two and at most 2^LineW. IdxW = clog2(NumCachelines); TagW = LineW - IdxW.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  invalidate all lines.
- mem_ready_i  in  1  memory accepts request.
- mem_req_o  out  1  memory request valid.
- mem_addr_o  out  LineW  cacheline address, equal to pc >> CachelineIdxBits.
- mem_valid_i  in  1  memory response valid; there is no backpressure on this path.
- mem_data_i  in  EncInstWidth*2^CachelineIdxBits  line data; word j is bits [j*EncInstWidth +: EncInstWidth] and holds the instruction at line offset j.
- ic_ready_o  out  1  cache accepts a fetch request.
- fe_valid_i  in  1  fetch request valid.
- fe_pc_i  in  PcWidth  PC of the fetch request.
- fe_act_mask_i  in  WarpWidth  active mask.
- fe_warp_id_i  in  WidW  warp ID.
- fe_subwarp_id_i  in  SwW  subwarp ID.
- dec_ready_i  in  1  decoder accepts the response.
- ic_valid_o  out  1  response valid.
- ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_subwarp_id_o  out  as the corresponding inputs  request context echoed unchanged.
- ic_inst_o  out  EncInstWidth  instruction stored at ic_pc_o.

Behaviour:
- Storage:
  - Per line: a valid bit, a TagW tag and 2^CachelineIdxBits instruction words, all held in flops.
  - Index = pc[CachelineIdxBits +: IdxW]; tag = upper TagW bits of pc; word offset = pc[CachelineIdxBits-1:0].
- FSM states: IDLE, MEM_REQ, MEM_WAIT.
- Output register: holds valid plus the response fields. A response is consumed when ic_valid_o && dec_ready_i.
- ic_ready_o = (state == IDLE) && (!ic_valid_o || dec_ready_i). This is combinational.
- Accept (fe_valid_i && ic_ready_o):
  - The request context is latched.
  - The hit check is combinational on fe_pc_i against the current array.
  - Hit: the output register is loaded at the next clock edge, so ic_valid_o rises 1 cycle after accept. The state stays IDLE, so back-to-back hits are accepted every cycle.
  - Miss: go to MEM_REQ.
- MEM_REQ: mem_req_o=1 and mem_addr_o is held stable until mem_ready_i; then go to MEM_WAIT.
- MEM_WAIT: on mem_valid_i:
  - write the line data, set the tag and set the valid bit;
  - load the output register with the selected word of mem_data_i;
  - go to IDLE.
- mem_valid_i in any state other than MEM_WAIT is ignored.
- Only one miss is outstanding at a time. Memory latency is arbitrary, at least 1 cycle after the request handshake.
- Flush:
  - On flush_i, every valid bit is cleared at the clock edge.
  - Flush wins over a same-cycle fill's valid-bit set; the fill's data still goes to the output.
  - In-flight requests are neither dropped nor reissued.
  - A same-cycle accept that hit uses the pre-flush array. It is still answered from that data, which is correct because instruction memory is static.
- Output stability: while ic_valid_o && !dec_ready_i, all ic_* outputs are held.
- Reset values:
  - state IDLE; all valid bits 0; ic_valid_o 0; mem_req_o 0.
  - ic_ready_o 1 after the reset cycle.
  - Data outputs 0.
- Reset mid-miss abandons the miss; any later mem_valid_i is ignored.
- Ordering: every accepted request produces exactly one response, in acceptance order.

Test Plan:
- Cold miss: reset, then fetch pc=0x05, wid=3, mask=4'b1011. Expect mem_req_o with mem_addr_o=0x01. Memory returns words {A0,A1,A2,A3}. Expect one response with pc=0x05 and inst=A1 and context echoed.
- Same-line hit: follow with pc=0x06 and pc=0x07. Expect no mem_req_o, ic_valid_o 1 cycle after each accept, and inst=A2 then A3.
- Conflict: with 16 lines and CachelineIdxBits=2, fetch pc=0x05 then pc=0x45 (same index, different tag). Both miss; mem_addr_o = 0x01 then 0x11. Correct data each time.
- Flush: after line 0x01 is filled, pulse flush_i for 1 cycle, then fetch pc=0x04. Expect a new miss with mem_addr_o=0x01 and correct data.
- Backpressure: hold dec_ready_i=0 for 5 cycles with a response pending. Expect ic_ready_o=0, stable outputs, no lost or duplicated responses. Randomise mem_ready_i and dec_ready_i for 1000 requests and compare every response against memory content at pc.
- Reset mid-miss: assert rst_i while in MEM_WAIT. Expect ic_valid_o=0, mem_req_o=0, the cache empty, and the late mem_valid_i ignored.

Source files
------------

// File: rtl/bgpu_instruction_cache.sv
// Direct-mapped, blocking instruction cache between the warp fetcher and the decoder.
// One miss outstanding at a time; responses leave in acceptance order.
module bgpu_instruction_cache #(
  parameter int unsigned PcWidth          = 9,
  parameter int unsigned NumWarps         = 16,
  parameter int unsigned WarpWidth        = 4,
  parameter int unsigned EncInstWidth     = 32,
  parameter int unsigned CachelineIdxBits = 2,
  parameter int unsigned NumCachelines    = 16,
  localparam int unsigned WidW      = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int unsigned SwW       = (WarpWidth > 1) ? $clog2(WarpWidth) : 1,
  localparam int unsigned LineW     = (CachelineIdxBits == 0) ? PcWidth : PcWidth - CachelineIdxBits,
  localparam int unsigned LineDataW = EncInstWidth * (1 << CachelineIdxBits)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  // instruction memory side
  input  logic                    mem_ready_i,
  output logic                    mem_req_o,
  output logic [LineW-1:0]        mem_addr_o,
  input  logic                    mem_valid_i,
  input  logic [LineDataW-1:0]    mem_data_i,
  // fetcher side
  output logic                    ic_ready_o,
  input  logic                    fe_valid_i,
  input  logic [PcWidth-1:0]      fe_pc_i,
  input  logic [WarpWidth-1:0]    fe_act_mask_i,
  input  logic [WidW-1:0]         fe_warp_id_i,
  input  logic [SwW-1:0]          fe_subwarp_id_i,
  // decoder side
  input  logic                    dec_ready_i,
  output logic                    ic_valid_o,
  output logic [PcWidth-1:0]      ic_pc_o,
  output logic [WarpWidth-1:0]    ic_act_mask_o,
  output logic [WidW-1:0]         ic_warp_id_o,
  output logic [SwW-1:0]          ic_subwarp_id_o,
  output logic [EncInstWidth-1:0] ic_inst_o
);

  localparam int unsigned NumWords = 1 << CachelineIdxBits;
  localparam int unsigned OffW     = (CachelineIdxBits > 0) ? CachelineIdxBits : 1;
  localparam int unsigned IdxW     = $clog2(NumCachelines);
  localparam int unsigned TagW     = LineW - IdxW;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT
  } state_e;

  typedef logic [NumWords-1:0][EncInstWidth-1:0] line_t;

  state_e                 state_q;
  logic [NumCachelines-1:0] valid_q;
  logic [TagW-1:0]        tag_q  [NumCachelines];
  line_t                  data_q [NumCachelines];

  logic [PcWidth-1:0]     req_pc_q;
  logic [WarpWidth-1:0]   req_mask_q;
  logic [WidW-1:0]        req_wid_q;
  logic [SwW-1:0]         req_swid_q;

  function automatic logic [IdxW-1:0] idx_of(input logic [PcWidth-1:0] pc);
    return pc[CachelineIdxBits +: IdxW];
  endfunction

  function automatic logic [TagW-1:0] tag_of(input logic [PcWidth-1:0] pc);
    return pc[PcWidth-1 -: TagW];
  endfunction

  // With one word per line there are no offset bits; word 0 is always selected.
  function automatic logic [OffW-1:0] off_of(input logic [PcWidth-1:0] pc);
    if (CachelineIdxBits == 0) return '0;
    return pc[OffW-1:0];
  endfunction

  logic [IdxW-1:0] fe_idx_c;
  logic [TagW-1:0] fe_tag_c;
  logic [OffW-1:0] fe_off_c;
  logic [IdxW-1:0] req_idx_c;
  logic [TagW-1:0] req_tag_c;
  logic [OffW-1:0] req_off_c;
  logic            hit_c;
  logic            accept_c;
  line_t           fill_line_c;

  assign fe_idx_c    = idx_of(fe_pc_i);
  assign fe_tag_c    = tag_of(fe_pc_i);
  assign fe_off_c    = off_of(fe_pc_i);
  assign req_idx_c   = idx_of(req_pc_q);
  assign req_tag_c   = tag_of(req_pc_q);
  assign req_off_c   = off_of(req_pc_q);
  assign fill_line_c = mem_data_i;

  // Hit lookup reads the array as it stands before any same-cycle flush.
  assign hit_c      = valid_q[fe_idx_c] && (tag_q[fe_idx_c] == fe_tag_c);
  assign ic_ready_o = (state_q == IDLE) && (!ic_valid_o || dec_ready_i);
  assign accept_c   = fe_valid_i && ic_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      mem_req_o       <= 1'b0;
      mem_addr_o      <= '0;
      req_pc_q        <= '0;
      req_mask_q      <= '0;
      req_wid_q       <= '0;
      req_swid_q      <= '0;
      ic_valid_o      <= 1'b0;
      ic_pc_o         <= '0;
      ic_act_mask_o   <= '0;
      ic_warp_id_o    <= '0;
      ic_subwarp_id_o <= '0;
      ic_inst_o       <= '0;
    end else begin
      if (ic_valid_o && dec_ready_i) ic_valid_o <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept_c) begin
            req_pc_q   <= fe_pc_i;
            req_mask_q <= fe_act_mask_i;
            req_wid_q  <= fe_warp_id_i;
            req_swid_q <= fe_subwarp_id_i;
            if (hit_c) begin
              ic_valid_o      <= 1'b1;
              ic_pc_o         <= fe_pc_i;
              ic_act_mask_o   <= fe_act_mask_i;
              ic_warp_id_o    <= fe_warp_id_i;
              ic_subwarp_id_o <= fe_subwarp_id_i;
              ic_inst_o       <= data_q[fe_idx_c][fe_off_c];
            end else begin
              state_q    <= MEM_REQ;
              mem_req_o  <= 1'b1;
              mem_addr_o <= LineW'(fe_pc_i >> CachelineIdxBits);
            end
          end
        end
        MEM_REQ: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            state_q   <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // Output register is free here: a miss is only accepted when it is.
          if (mem_valid_i) begin
            data_q[req_idx_c]  <= fill_line_c;
            tag_q[req_idx_c]   <= req_tag_c;
            valid_q[req_idx_c] <= 1'b1;
            ic_valid_o         <= 1'b1;
            ic_pc_o            <= req_pc_q;
            ic_act_mask_o      <= req_mask_q;
            ic_warp_id_o       <= req_wid_q;
            ic_subwarp_id_o    <= req_swid_q;
            ic_inst_o          <= fill_line_c[req_off_c];
            state_q            <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Flush overrides a same-cycle fill's valid-bit set.
      if (flush_i) valid_q <= '0;
    end
  end

endmodule

// File: tb/tb_bgpu_instruction_cache.sv
// Scoreboard bench for bgpu_instruction_cache: directed miss/hit/flush/reset cases plus a randomised handshake run.
module tb_bgpu_instruction_cache;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         mem_ready_i;
  logic         mem_req_o;
  logic [6:0]   mem_addr_o;
  logic         mem_valid_i;
  logic [127:0] mem_data_i;
  logic         ic_ready_o;
  logic         fe_valid_i;
  logic [8:0]   fe_pc_i;
  logic [3:0]   fe_act_mask_i;
  logic [3:0]   fe_warp_id_i;
  logic [1:0]   fe_subwarp_id_i;
  logic         dec_ready_i;
  logic         ic_valid_o;
  logic [8:0]   ic_pc_o;
  logic [3:0]   ic_act_mask_o;
  logic [3:0]   ic_warp_id_o;
  logic [1:0]   ic_subwarp_id_o;
  logic [31:0]  ic_inst_o;

  bgpu_instruction_cache dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .ic_ready_o(ic_ready_o), .fe_valid_i(fe_valid_i), .fe_pc_i(fe_pc_i),
    .fe_act_mask_i(fe_act_mask_i), .fe_warp_id_i(fe_warp_id_i), .fe_subwarp_id_i(fe_subwarp_id_i),
    .dec_ready_i(dec_ready_i), .ic_valid_o(ic_valid_o), .ic_pc_o(ic_pc_o),
    .ic_act_mask_o(ic_act_mask_o), .ic_warp_id_o(ic_warp_id_o),
    .ic_subwarp_id_o(ic_subwarp_id_o), .ic_inst_o(ic_inst_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [8:0]  pc;
    logic [3:0]  mask;
    logic [3:0]  wid;
    logic [1:0]  swid;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] imem [512];
  int          total = 0;
  int          bad   = 0;
  int          miss_cnt = 0;
  logic [6:0]  last_addr = '0;
  int          dec_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit          mem_rand = 1'b0;
  int          mem_lat  = 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [6:0] a);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = imem[{a, 2'(j)}];
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic fetch(input logic [8:0] pc, input logic [3:0] mask,
                       input logic [3:0] wid, input logic [1:0] swid);
    int  n;
    bit  ok;
    fe_pc_i = pc; fe_act_mask_i = mask; fe_warp_id_i = wid; fe_subwarp_id_i = swid;
    fe_valid_i = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk_i);
      if (ic_ready_o) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: pc=%0h not accepted within 300 cycles", pc);
      fe_valid_i = 1'b0;
      return;
    end
    sb.push_back('{pc: pc, mask: mask, wid: wid, swid: swid, inst: imem[pc]});
    @(posedge clk_i); #1;
    fe_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    check("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Instruction memory: latency counted from the request handshake.
  initial begin
    bit         hs, pend;
    logic [6:0] haddr, paddr;
    int         cnt;
    mem_ready_i = 1'b1; mem_valid_i = 1'b0; mem_data_i = '0;
    pend = 1'b0; cnt = 0; paddr = '0;
    forever begin
      @(negedge clk_i);
      hs    = mem_req_o && mem_ready_i && !rst_i;
      haddr = mem_addr_o;
      if (hs) begin
        miss_cnt++;
        last_addr = haddr;
      end
      @(posedge clk_i); #1;
      mem_valid_i = 1'b0;
      mem_ready_i = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hs) begin
        pend  = 1'b1;
        paddr = haddr;
        cnt   = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          mem_valid_i = 1'b1;
          mem_data_i  = line_of(paddr);
          pend        = 1'b0;
        end
      end
    end
  end

  // Decoder ready pattern.
  initial begin
    dec_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (dec_mode)
        1:       dec_ready_i = 1'($urandom_range(0, 1));
        2:       dec_ready_i = 1'b0;
        default: dec_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: every consumed response is popped and compared in order.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk_i);
      if (!rst_i && ic_valid_o && dec_ready_i) begin
        got = '{pc: ic_pc_o, mask: ic_act_mask_o, wid: ic_warp_id_o,
                swid: ic_subwarp_id_o, inst: ic_inst_o};
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: got pc=%0h inst=%0h expected no response", ic_pc_o, ic_inst_o);
        end else begin
          e = sb.pop_front();
          check("resp", 64'(got), 64'(e));
        end
      end
    end
  end

  initial begin
    int m0;
    int n;
    for (int i = 0; i < 512; i++) imem[i] = {16'hC0DE ^ 16'(i * 7), 7'd0, 9'(i)};
    imem[9'h04] = 32'hA0A0_A0A0; imem[9'h05] = 32'hA1A1_A1A1;
    imem[9'h06] = 32'hA2A2_A2A2; imem[9'h07] = 32'hA3A3_A3A3;
    imem[9'h44] = 32'hB0B0_B0B0; imem[9'h45] = 32'hB1B1_B1B1;
    imem[9'h46] = 32'hB2B2_B2B2; imem[9'h47] = 32'hB3B3_B3B3;

    rst_i = 1'b1; flush_i = 1'b0; fe_valid_i = 1'b0;
    fe_pc_i = '0; fe_act_mask_i = '0; fe_warp_id_i = '0; fe_subwarp_id_i = '0;
    step(3);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ic_valid", 64'(ic_valid_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_ic_ready", 64'(ic_ready_o), 64'd1);
    check("rst_ic_inst", 64'(ic_inst_o), 64'd0);
    check("rst_ic_pc", 64'(ic_pc_o), 64'd0);
    step(1);

    // Cold miss
    fetch(9'h05, 4'b1011, 4'd3, 2'd1);
    drain();
    check("cold_miss_cnt", 64'(miss_cnt), 64'd1);
    check("cold_miss_addr", 64'(last_addr), 64'h01);

    // Same-line hits with one-cycle latency
    fetch(9'h06, 4'b0110, 4'd5, 2'd2);
    @(negedge clk_i);
    check("hit6_valid", 64'(ic_valid_o), 64'd1);
    check("hit6_inst", 64'(ic_inst_o), 64'hA2A2_A2A2);
    step(1);
    fetch(9'h07, 4'b1111, 4'd9, 2'd3);
    @(negedge clk_i);
    check("hit7_valid", 64'(ic_valid_o), 64'd1);
    check("hit7_inst", 64'(ic_inst_o), 64'hA3A3_A3A3);
    step(1);
    drain();
    check("hit_no_miss", 64'(miss_cnt), 64'd1);

    // Conflict: same index, different tag
    fetch(9'h45, 4'b0001, 4'd1, 2'd0);
    drain();
    check("conf45_cnt", 64'(miss_cnt), 64'd2);
    check("conf45_addr", 64'(last_addr), 64'h11);
    fetch(9'h05, 4'b1011, 4'd3, 2'd1);
    drain();
    check("conf05_cnt", 64'(miss_cnt), 64'd3);
    check("conf05_addr", 64'(last_addr), 64'h01);

    // Flush forces a refill of a previously valid line
    flush_i = 1'b1; step(1); flush_i = 1'b0;
    fetch(9'h04, 4'b1000, 4'd15, 2'd0);
    drain();
    check("flush_cnt", 64'(miss_cnt), 64'd4);
    check("flush_addr", 64'(last_addr), 64'h01);

    // Backpressure: response held stable while the decoder stalls
    dec_mode = 2; step(1);
    fetch(9'h06, 4'b0101, 4'd7, 2'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("bp_valid", 64'(ic_valid_o), 64'd1);
      check("bp_ready", 64'(ic_ready_o), 64'd0);
      check("bp_pc", 64'(ic_pc_o), 64'h06);
      check("bp_inst", 64'(ic_inst_o), 64'hA2A2_A2A2);
    end
    step(1);
    dec_mode = 0;
    drain();

    // Randomised handshakes
    dec_mode = 1; mem_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 97 == 50) begin
        flush_i = 1'b1; step(1); flush_i = 1'b0;
      end
      fetch((i % 64 == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 127)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    drain();
    dec_mode = 0; mem_rand = 1'b0;
    step(4);

    // Reset while waiting for memory
    flush_i = 1'b1; step(1); flush_i = 1'b0;
    mem_lat = 8;
    m0 = miss_cnt;
    fetch(9'h40, 4'b0011, 4'd2, 2'd2);
    n = 0;
    while (miss_cnt == m0 && n < 50) begin
      step(1);
      n++;
    end
    check("rstmiss_handshake", 64'(miss_cnt), 64'(m0 + 1));
    step(2);
    rst_i = 1'b1; step(1); rst_i = 1'b0;
    sb.delete();
    @(negedge clk_i);
    check("rstmiss_valid", 64'(ic_valid_o), 64'd0);
    check("rstmiss_req", 64'(mem_req_o), 64'd0);
    check("rstmiss_ready", 64'(ic_ready_o), 64'd1);
    step(12);
    @(negedge clk_i);
    check("rstmiss_late_ignored", 64'(ic_valid_o), 64'd0);
    step(1);
    mem_lat = 1;
    m0 = miss_cnt;
    fetch(9'h05, 4'b1011, 4'd3, 2'd1);
    drain();
    check("rstmiss_empty_cache", 64'(miss_cnt), 64'(m0 + 1));

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
